// File: rtl/param_updown_counter_pkg.sv
// param_counter_pkg: shared types and constants for param_updown_counter.
//   mode_e  : counting mode selector (WRAP / MODULO / SAT / ONESHOT)
//   state_e : one-shot sequencer state (RUN / DONE)
//   DIR_UP / DIR_DOWN : values of the dir input
package param_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_MODULO  = 2'd1,
    MODE_SAT     = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/param_updown_counter_prescaler.sv
// tick_prescaler: enable divider for param_updown_counter.
//   clk, rst  : clock, async active-high reset
//   en        : advance enable; psc holds when low
//   clear     : accepted load; restarts the period
//   prescale  : tick every prescale+1 enabled cycles
//   tick      : combinational, high on the enabled cycle that ends a period
module tick_prescaler #(
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [PSC_W-1:0] prescale,
  output logic             tick
);

  logic [PSC_W-1:0] psc;

  assign tick = en && (psc == prescale);

  // If prescale is lowered below the current psc, psc runs on and wraps
  // through zero before matching again; no special handling is wanted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       psc <= '0;
    else if (clear) psc <= '0;
    else if (tick)  psc <= '0;
    else if (en)    psc <= psc + 1'b1;
  end

endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: parameterised up/down counter on a shared bus.
//   Parameters: WIDTH (2..32) counter/bus width, PSC_W prescaler width.
//   clk, rst      : clock, async active-high reset
//   en            : count enable (gates the prescaler)
//   load/load_val : synchronous parallel load, accepted only while oe=0
//   dir           : 0 up, 1 down
//   mode          : 0 WRAP, 1 MODULO, 2 SAT, 3 ONESHOT
//   limit         : modulo / one-shot bound
//   prescale      : tick every prescale+1 enabled cycles
//   oe            : drive count onto the bus
//   count_out     : current count; count_oe : per-bit drive enable (= oe)
//   tc            : registered one-cycle terminal-count pulse
//   done          : one-shot finished flag
// Optional (define PARAM_COUNTER_CAPTURE_EN):
//   capture -> cap_val/cap_valid snapshot of the pre-update count.
import param_counter_pkg::*;

module param_updown_counter #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [PSC_W-1:0] prescale,
  input  logic             oe,
`ifdef PARAM_COUNTER_CAPTURE_EN
  input  logic             capture,
  output logic [WIDTH-1:0] cap_val,
  output logic             cap_valid,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] count_oe,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX = '1;

  mode_e            mode_q;
  state_e           state;
  logic [WIDTH-1:0] count;
  logic             load_acc;
  logic             tick;

  assign mode_q    = mode_e'(mode);
  assign load_acc  = load && !oe;   // bus is ours while driving; no load then
  assign count_out = count;
  assign count_oe  = {WIDTH{oe}};   // not reset: tracks oe directly

  tick_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clear    (load_acc),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
      state <= ST_RUN;
    end else if (load_acc) begin
      count <= load_val;
      tc    <= 1'b0;
      done  <= 1'b0;
      state <= ST_RUN;
    end else begin
      tc <= 1'b0;
      // Leaving ONESHOT releases DONE; this edge then counts under the new mode.
      if (state == ST_DONE && mode_q != MODE_ONESHOT) begin
        state <= ST_RUN;
        done  <= 1'b0;
      end
      if (tick) begin
        case (mode_q)
          MODE_WRAP: begin
            if (dir == DIR_UP) begin
              count <= count + 1'b1;
              tc    <= (count == MAX);
            end else begin
              count <= count - 1'b1;
              tc    <= (count == '0);
            end
          end
          MODE_MODULO: begin
            if (dir == DIR_UP) begin
              if (count >= limit) begin
                count <= '0;
                tc    <= 1'b1;
              end else begin
                count <= count + 1'b1;
              end
            end else begin
              if (count == '0) begin
                count <= limit;
                tc    <= 1'b1;
              end else begin
                count <= count - 1'b1;
              end
            end
          end
          MODE_SAT: begin
            // tc only on the step that lands on the rail, not while parked.
            if (dir == DIR_UP) begin
              if (count != MAX) begin
                count <= count + 1'b1;
                tc    <= (count == MAX - 1'b1);
              end
            end else begin
              if (count != '0) begin
                count <= count - 1'b1;
                tc    <= (count == {{(WIDTH-1){1'b0}}, 1'b1});
              end
            end
          end
          MODE_ONESHOT: begin
            if (state == ST_RUN) begin
              if ((dir == DIR_UP && count == limit) ||
                  (dir == DIR_DOWN && count == '0)) begin
                state <= ST_DONE;
                done  <= 1'b1;
                tc    <= 1'b1;
              end else if (dir == DIR_UP) begin
                count <= count + 1'b1;   // above limit: wraps through 0
              end else begin
                count <= count - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PARAM_COUNTER_CAPTURE_EN
  // Snapshot is of the count before this edge's update; a simultaneous
  // capture wins over the load's clear of cap_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_val   <= '0;
      cap_valid <= 1'b0;
    end else if (capture) begin
      cap_val   <= count;
      cap_valid <= 1'b1;
    end else if (load_acc) begin
      cap_valid <= 1'b0;
    end
  end
`endif

endmodule
